// File: rtl/dp_arbiter.sv
// dp_arbiter: shares one datapath between four clients.
//
// Each client raises req_start while its req_finished is high; the instruction is captured
// into a per-client buffer and the client is queued. A round-robin FSM picks the next queued
// client starting at ptr, presents its instruction with a 2-cycle dp_start pulse and waits
// for dp_finished, then returns dp_result on that client's result slice.
//
// Ports
//   clock           rising-edge clock
//   resetn          synchronous active-low reset
//   req_start       per-client start (client i on bit i)
//   req_instruction per-client instruction (client i on bits [i*IW +: IW])
//   req_finished    per-client finished, 1 = idle or done
//   req_result      per-client result (client i on bits [i*RW +: RW])
//   dp_start        start to the shared datapath
//   dp_instruction  instruction to the datapath, held until the next grant
//   dp_finished     datapath finished
//   dp_result       datapath result
//   grant           index of the client currently or last served
//   busy            high while an operation is in flight

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 8
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 8
`endif

module dp_arbiter #(
  parameter int unsigned IW = `INSTRUCTION_WIDTH,
  parameter int unsigned RW = `RESULT_WIDTH
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [3:0]      req_start,
  input  logic [4*IW-1:0] req_instruction,
  output logic [3:0]      req_finished,
  output logic [4*RW-1:0] req_result,
  output logic            dp_start,
  output logic [IW-1:0]   dp_instruction,
  input  logic            dp_finished,
  input  logic [RW-1:0]   dp_result,
  output logic [1:0]      grant,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StHold, StWait} state_e;

  state_e        state_q;
  logic [3:0]    pending_q;
  logic [3:0]    finished_q;
  logic [1:0]    ptr_q;
  logic [1:0]    grant_q;
  logic          dp_start_q;
  logic [IW-1:0] dp_instr_q;
  logic [IW-1:0] inst_buf_q [4];
  logic [RW-1:0] result_q   [4];

  logic [1:0]    pick;
  logic          pick_valid;
  logic [1:0]    pick_idx;

  // Round-robin pick: scan from the farthest offset down so the nearest pending client to
  // ptr is the last (winning) assignment.
  always_comb begin
    pick       = ptr_q;
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      pick_idx = ptr_q + 2'(k);
      if (pending_q[pick_idx]) begin
        pick       = pick_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= StIdle;
      pending_q  <= 4'b0000;
      finished_q <= 4'b1111;
      ptr_q      <= 2'd0;
      grant_q    <= 2'd0;
      dp_start_q <= 1'b0;
      dp_instr_q <= '0;
      for (int i = 0; i < 4; i++) begin
        inst_buf_q[i] <= '0;
        result_q[i]   <= '0;
      end
    end else begin
      // Acceptance runs alongside the FSM; a served client is never acceptable because its
      // finished bit is low, so the two never touch the same client at one edge.
      for (int i = 0; i < 4; i++) begin
        if (req_start[i] && finished_q[i]) begin
          pending_q[i]  <= 1'b1;
          finished_q[i] <= 1'b0;
          inst_buf_q[i] <= req_instruction[i*IW +: IW];
        end
      end

      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q    <= pick;
            dp_start_q <= 1'b1;
            dp_instr_q <= inst_buf_q[pick];
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StHold;
        end
        StHold: begin
          dp_start_q <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (dp_finished) begin
            result_q[grant_q]   <= dp_result;
            finished_q[grant_q] <= 1'b1;
            pending_q[grant_q]  <= 1'b0;
            ptr_q               <= grant_q + 2'd1;
            state_q             <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    req_result = '0;
    for (int i = 0; i < 4; i++) begin
      req_result[i*RW +: RW] = result_q[i];
    end
  end

  assign req_finished   = finished_q;
  assign dp_start       = dp_start_q;
  assign dp_instruction = dp_instr_q;
  assign grant          = grant_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: doc/dp_arbiter.md
DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 The block SHALL have parameter IW, default `INSTRUCTION_WIDTH, datapath instruction width.
REQ-002 The block SHALL have parameter RW, default `RESULT_WIDTH, datapath result width.
REQ-003 The block SHALL have port clock  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port req_start  input  4  per-client start (client i on bit i).
REQ-006 The block SHALL have port req_instruction  input  4*IW  per-client instruction (client i on bits [i*IW +: IW]).
REQ-007 The block SHALL have port req_finished  output  4  per-client finished, 1 = idle or done.
REQ-008 The block SHALL have port req_result  output  4*RW  per-client result (client i on bits [i*RW +: RW]).
REQ-009 The block SHALL have port dp_start  output  1  start to the shared datapath.
REQ-010 The block SHALL have port dp_instruction  output  IW  instruction to the datapath.
REQ-011 The block SHALL have port dp_finished  input  1  datapath finished.
REQ-012 The block SHALL have port dp_result  input  RW  datapath result.
REQ-013 The block SHALL have port grant  output  2  index of the client currently or last served.
REQ-014 The block SHALL have port busy  output  1  1 while in ISSUE, HOLD or WAIT.

Function
REQ-015 Client acceptance: at an edge where req_start[i]=1 and req_finished[i]=1, the block SHALL set pending[i]=1, latch req_instruction slice i into buf[i], and drive req_finished[i]=0 from that edge (a 1-cycle response).
REQ-016 The block SHALL ignore req_start[i] while req_finished[i]=0: no re-latch and no second request.
REQ-017 The FSM SHALL have states IDLE, ISSUE, HOLD and WAIT, all registered.
REQ-018 IDLE: if any pending bit is set, the block SHALL pick the first pending client in round-robin order starting at ptr, set grant, drive dp_start=1 and dp_instruction=buf[grant], and go to ISSUE; otherwise it SHALL stay in IDLE with dp_start=0.
REQ-019 ISSUE: the block SHALL keep dp_start=1 and go to HOLD, so dp_start is high for exactly 2 cycles.
REQ-020 HOLD: the block SHALL drive dp_start=0 and go to WAIT.
REQ-021 WAIT: at an edge where dp_finished=1, the block SHALL latch dp_result into result slice grant, set req_finished[grant]=1, clear pending[grant], set ptr=grant+1 (mod 4), and go to IDLE.
REQ-022 WAIT SHALL have no timeout; the block SHALL remain in WAIT while dp_finished=0.
REQ-023 dp_instruction SHALL hold its value from grant until the next grant.
REQ-024 Minimum pending-to-dp_start latency SHALL be 1 cycle; back-to-back operations SHALL be separated by 1 IDLE cycle.
REQ-025 A request accepted while another client is served SHALL be queued and never dropped; all 4 clients may be pending at once.
REQ-026 A client's result slice SHALL change only on completion of that client's own operation.
REQ-027 Fairness: with all 4 clients continuously pending, the grant sequence SHALL rotate 0,1,2,3,0,...
REQ-028 Simultaneous events: a new acceptance (any client) at the same edge as a WAIT completion SHALL both take effect; the new client SHALL be eligible at the next IDLE.
REQ-029 ptr SHALL be 2 bits and wrap from 3 to 0.

Reset
REQ-030 While resetn=0 at an edge, the block SHALL set state=IDLE, pending=0, ptr=0, grant=0, busy=0, dp_start=0, dp_instruction=0, req_finished=4'b1111, req_result=0, and buf=0.
REQ-031 Reset mid-operation SHALL abandon the in-flight and queued operations without completion; a dp_finished seen after reset SHALL be ignored in IDLE.

Verification
REQ-032 Single request: client 2 pulses start for 2 cycles with instruction 0x15; datapath finishes 3 cycles after dp_start falls with result 0x7 -> dp_instruction=0x15, dp_start high 2 cycles, req_finished[2] low until completion, then high with result slice 2 = 0x7, grant=2.
REQ-033 Contention: clients 0, 1 and 3 request on the same edge with ptr=0 -> service order 0,1,3; each finished rises only at its own completion; ptr=0 after the sequence.
REQ-034 Round-robin wrap: client 3 completes (ptr=0), then clients 3 and 0 request together -> client 0 is served first.
REQ-035 Re-start ignored: client 1 re-asserts start while pending -> one datapath operation only, buf[1] unchanged.
REQ-036 Reset mid-WAIT with clients 0 and 2 pending -> all finished=1, dp_start=0, busy=0; a later dp_finished=1 causes no result update.
REQ-037 Result isolation: client 0's result is 0xA; a later client 1 operation returns 0xB -> result slice 0 remains 0xA.
